// File: rtl/key_progress.sv
// Per-stage key-progress tracker: collects three keys in order, then opens the door and signals stage clear.
// Latency: key_find/pickup/stage_clear update on the edge that samples interact; door_open is registered with the FSM.
// Backpressure: none. interact is a fire-and-forget pulse and is ignored outside SEARCH/DOOR (e.g. during cooldown).
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   state               : current scene-FSM state; tracking runs only while state == STAGE1
//   player_x, player_y  : player top-left corner in 320x240 space
//   interact            : one-cycle action-button pulse
//   key_find            : 0..2 = index of next key to collect, 3 = all collected
//   door_open           : high while the tracker waits at the open door
//   pickup, stage_clear : one-cycle event pulses
module key_progress #(
  parameter logic [3:0] STAGE1   = 4'd2,
  parameter int         PLAYER_W = 16,
  parameter int         PLAYER_H = 16,
  parameter int         KEY_SIZE = 20,
  parameter int         KEY0_X   = 65,
  parameter int         KEY0_Y   = 35,
  parameter int         KEY1_X   = 235,
  parameter int         KEY1_Y   = 35,
  parameter int         KEY2_X   = 235,
  parameter int         KEY2_Y   = 205,
  parameter int         DOOR_X   = 150,
  parameter int         DOOR_Y   = 5,
  parameter int         DOOR_W   = 20,
  parameter int         DOOR_H   = 30,
  parameter int         COOLDOWN = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       interact,
  output logic [1:0] key_find,
  output logic       door_open,
  output logic       pickup,
  output logic       stage_clear
);

  // Counter only ever holds COOLDOWN-1 down to 0.
  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_COOLDOWN,
    S_DOOR,
    S_CLEARED
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [1:0]       key_find_q, key_find_d;
  logic             door_open_q, door_open_d;
  logic             pickup_q, pickup_d;
  logic             stage_clear_q, stage_clear_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Rectangle overlap in 10 bits so px+PLAYER_W never wraps.
  // Strict compares: touching edges with no shared pixel is not a hit.
  function automatic logic rect_hit(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] rx, input logic [9:0] ry,
                                    input logic [9:0] rw, input logic [9:0] rh);
    return (px < rx + rw) && (px + 10'(PLAYER_W) > rx) &&
           (py < ry + rh) && (py + 10'(PLAYER_H) > ry);
  endfunction

  logic [9:0] px, py;
  logic [9:0] key_x, key_y;
  logic       key_hit, door_hit;

  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};

  // Only the current key is a valid target; with all keys found there is no target,
  // which also keeps key_find from ever advancing past 3.
  always_comb begin
    key_x = 10'(KEY0_X);
    key_y = 10'(KEY0_Y);
    case (key_find_q)
      2'd1:    begin key_x = 10'(KEY1_X); key_y = 10'(KEY1_Y); end
      2'd2:    begin key_x = 10'(KEY2_X); key_y = 10'(KEY2_Y); end
      default: begin key_x = 10'(KEY0_X); key_y = 10'(KEY0_Y); end
    endcase
  end

  assign key_hit  = (key_find_q != 2'd3) &&
                    rect_hit(px, py, key_x, key_y, 10'(KEY_SIZE), 10'(KEY_SIZE));
  assign door_hit = rect_hit(px, py, 10'(DOOR_X), 10'(DOOR_Y), 10'(DOOR_W), 10'(DOOR_H));

  always_comb begin
    fsm_d         = fsm_q;
    key_find_d    = key_find_q;
    cnt_d         = cnt_q;
    pickup_d      = 1'b0;
    stage_clear_d = 1'b0;

    if (state != STAGE1) begin
      // Leaving the stage from anywhere, including mid-cooldown, restarts progress.
      fsm_d      = S_IDLE;
      key_find_d = 2'd0;
      cnt_d      = '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          fsm_d      = S_SEARCH;
          key_find_d = 2'd0;
          cnt_d      = '0;
        end
        S_SEARCH: begin
          if (interact && key_hit) begin
            key_find_d = key_find_q + 2'd1;
            pickup_d   = 1'b1;
            cnt_d      = CNT_LOAD;
            fsm_d      = S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          // interact is ignored here, including on the cycle the count hits 0.
          if (cnt_q == '0) begin
            fsm_d = (key_find_q == 2'd3) ? S_DOOR : S_SEARCH;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DOOR: begin
          if (interact && door_hit) begin
            stage_clear_d = 1'b1;
            fsm_d         = S_CLEARED;
          end
        end
        S_CLEARED: begin
          fsm_d = S_CLEARED;
        end
        default: begin
          fsm_d      = S_IDLE;
          key_find_d = 2'd0;
          cnt_d      = '0;
        end
      endcase
    end

    // Registered alongside the state so it is high exactly while in DOOR.
    door_open_d = (fsm_d == S_DOOR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q         <= S_IDLE;
      key_find_q    <= 2'd0;
      door_open_q   <= 1'b0;
      pickup_q      <= 1'b0;
      stage_clear_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      fsm_q         <= fsm_d;
      key_find_q    <= key_find_d;
      door_open_q   <= door_open_d;
      pickup_q      <= pickup_d;
      stage_clear_q <= stage_clear_d;
      cnt_q         <= cnt_d;
    end
  end

  assign key_find    = key_find_q;
  assign door_open   = door_open_q;
  assign pickup      = pickup_q;
  assign stage_clear = stage_clear_q;

endmodule

// File: tb/tb_key_progress.sv
// Testbench for key_progress: reference model feeds an expected-output queue,
// DUT outputs are popped and compared one cycle after each driven input set.
module tb_key_progress;

  localparam int COOL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state = 4'd0;
  logic [8:0] player_x = 9'd0;
  logic [8:0] player_y = 9'd0;
  logic       interact = 1'b0;
  logic [1:0] key_find;
  logic       door_open;
  logic       pickup;
  logic       stage_clear;

  key_progress #(.COOLDOWN(COOL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .player_x    (player_x),
    .player_y    (player_y),
    .interact    (interact),
    .key_find    (key_find),
    .door_open   (door_open),
    .pickup      (pickup),
    .stage_clear (stage_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kf;
    int dopen;
    int pk;
    int sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase 0 idle, 1 search, 2 cooldown, 3 door, 4 cleared.
  int m_phase = 0;
  int m_kf    = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit overlap(int x, int y, int rx, int ry, int rw, int rh);
    return (x < rx + rw) && (x + 16 > rx) && (y < ry + rh) && (y + 16 > ry);
  endfunction

  function automatic bit on_key(int kf, int x, int y);
    case (kf)
      0:       return overlap(x, y, 65, 35, 20, 20);
      1:       return overlap(x, y, 235, 35, 20, 20);
      2:       return overlap(x, y, 235, 205, 20, 20);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input bit r, input int st, input int x, input int y, input bit it,
                       output exp_t e);
    e.pk = 0;
    e.sc = 0;
    if (!r || st != 2) begin
      m_phase = 0;
      m_kf    = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: if (it && on_key(m_kf, x, y)) begin
             m_kf++;
             e.pk    = 1;
             m_cnt   = COOL - 1;
             m_phase = 2;
           end
        2: if (m_cnt == 0) m_phase = (m_kf == 3) ? 3 : 1;
           else m_cnt--;
        3: if (it && overlap(x, y, 150, 5, 20, 30)) begin
             e.sc    = 1;
             m_phase = 4;
           end
        default: ;
      endcase
    end
    e.kf    = m_kf;
    e.dopen = (m_phase == 3) ? 1 : 0;
  endtask

  task automatic step(input bit r, input int st, input int x, input int y, input bit it);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n    = r;
    state    = 4'(st);
    player_x = 9'(x);
    player_y = 9'(y);
    interact = it;
    model(r, st, x, y, it, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check("key_find",    32'(key_find),    32'(g.kf));
    check("door_open",   32'(door_open),   32'(g.dopen));
    check("pickup",      32'(pickup),      32'(g.pk));
    check("stage_clear", 32'(stage_clear), 32'(g.sc));
  endtask

  initial begin
    // 1. reset and idle outside STAGE1
    step(0, 0, 60, 30, 0);
    step(0, 0, 60, 30, 0);
    step(1, 0, 60, 30, 1);
    step(1, 0, 60, 30, 0);
    step(1, 0, 60, 30, 1);
    check("idle_kf", 32'(key_find), 32'd0);

    // 2/3. enter stage, edge case then key 0
    step(1, 2, 49, 35, 0);
    step(1, 2, 49, 35, 1);
    check("edge_no_hit", 32'(key_find), 32'd0);
    step(1, 2, 50, 35, 1);
    check("k0_pickup", 32'(pickup), 32'd1);
    check("k0_kf", 32'(key_find), 32'd1);

    // 4. interact on key 1 every cooldown cycle, incl. the one where count hits 0
    repeat (COOL) step(1, 2, 230, 30, 1);
    check("cool_ignored", 32'(key_find), 32'd1);
    step(1, 2, 60, 30, 1);
    check("order_strict", 32'(key_find), 32'd1);
    step(1, 2, 230, 30, 1);
    check("k1_kf", 32'(key_find), 32'd2);
    repeat (COOL) step(1, 2, 230, 200, 0);
    step(1, 2, 230, 200, 1);
    check("k2_kf", 32'(key_find), 32'd3);
    repeat (COOL - 1) step(1, 2, 230, 200, 0);
    check("door_early", 32'(door_open), 32'd0);
    step(1, 2, 230, 200, 1);
    check("door_open", 32'(door_open), 32'd1);

    // 5. door
    step(1, 2, 100, 100, 1);
    check("door_miss", 32'(stage_clear), 32'd0);
    step(1, 2, 140, 10, 1);
    check("clear_pulse", 32'(stage_clear), 32'd1);
    step(1, 2, 140, 10, 0);
    check("clear_width", 32'(stage_clear), 32'd0);
    check("door_closed", 32'(door_open), 32'd0);
    step(1, 2, 140, 10, 1);
    step(1, 2, 50, 35, 1);
    check("cleared_kf", 32'(key_find), 32'd3);
    step(1, 8, 140, 10, 0);
    check("leave_kf", 32'(key_find), 32'd0);

    // 6. abort mid-cooldown at key_find=2
    step(1, 2, 60, 30, 0);
    step(1, 2, 60, 30, 1);
    repeat (COOL) step(1, 2, 230, 30, 0);
    step(1, 2, 230, 30, 1);
    step(1, 2, 230, 30, 0);
    check("pre_abort_kf", 32'(key_find), 32'd2);
    step(1, 8, 230, 30, 0);
    check("abort_kf", 32'(key_find), 32'd0);
    step(1, 2, 60, 30, 0);
    step(1, 2, 60, 30, 1);
    check("restart_kf", 32'(key_find), 32'd1);
    step(1, 2, 60, 30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
